// File: rtl/cmp_pkg.sv
// Shared comparison op codes for the branch compare pipeline.
// Imported by cmp_core and branch_cmp_pipe.
package cmp_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_EQ  = 3'd0,
        OP_NE  = 3'd1,
        OP_LT  = 3'd2,
        OP_GE  = 3'd3,
        OP_LTU = 3'd4,
        OP_GEU = 3'd5,
        OP_RS6 = 3'd6,
        OP_RS7 = 3'd7
    } cmp_op_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational branch comparator: EQ/NE, signed and unsigned LT/GE.
// Op codes 6 and 7 are reserved and flag err with taken low.
import cmp_pkg::*;

module cmp_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  cmp_op_t          op,
    output logic             taken,
    output logic             err
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        unique case (1'b1)
            (op == OP_EQ):  taken = eq;
            (op == OP_NE):  taken = !eq;
            (op == OP_LT):  taken = lt;
            (op == OP_GE):  taken = !lt;
            (op == OP_LTU): taken = ltu;
            (op == OP_GEU): taken = !ltu;
            default:        err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Two-stage valid/ready branch compare pipeline with flush.
// Optional saturating result counters when CMP_STATS_EN is defined.
import cmp_pkg::*;

module branch_cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
`ifdef CMP_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] taken_cnt
`endif
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    cmp_op_t          s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic             c_taken;
    logic             c_err;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    // reset_n gates in_ready so nothing is offered while in reset
    assign in_ready  = reset_n && s1_adv && !flush;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_op  <= cmp_op_t'(op);
            s1_tag <= in_tag;
        end
    end

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a    (s1_a),
        .b    (s1_b),
        .op   (s1_op),
        .taken(c_taken),
        .err  (c_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_taken <= 1'b0;
            out_err   <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_taken <= c_taken;
                    out_err   <= c_err;
                    out_tag   <= s1_tag;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
        end
    end

`ifdef CMP_STATS_EN
    logic out_hs;

    // a result dropped by a same-cycle flush is not counted
    assign out_hs = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_cnt <= '0;
            taken_cnt <= '0;
        end else if (stats_clr) begin
            total_cnt <= '0;
            taken_cnt <= '0;
        end else if (out_hs) begin
            if (total_cnt != '1) begin
                total_cnt <= total_cnt + CNT_W'(1);
            end
            if (out_taken && taken_cnt != '1) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt;

    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Scoreboard bench for branch_cmp_pipe: directed cases plus random traffic.
// Define CMP_STATS_EN to also exercise the saturating counters.
module tb_branch_cmp_pipe;
    import cmp_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic             taken;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_taken;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;
`ifdef CMP_STATS_EN
    logic             stats_clr = 1'b0;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] taken_cnt;
`endif

    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errors = 0;
    logic last_acc;
    logic [TAG_W-1:0] st_tag;
    logic st_taken;

    always #5 clk = ~clk;

    branch_cmp_pipe #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_taken(out_taken),
        .out_err  (out_err),
        .out_tag  (out_tag)
`ifdef CMP_STATS_EN
        ,
        .stats_clr(stats_clr),
        .total_cnt(total_cnt),
        .taken_cnt(taken_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: branch rules evaluated on 64-bit integers
    function automatic exp_t model(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [2:0] o,
                                   input logic [TAG_W-1:0] t);
        exp_t   e;
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        e.tag = t;
        e.err = (o > 3'd5);
        case (o)
            3'd0:    e.taken = (ux == uy);
            3'd1:    e.taken = (ux != uy);
            3'd2:    e.taken = (sx < sy);
            3'd3:    e.taken = (sx >= sy);
            3'd4:    e.taken = (ux < uy);
            3'd5:    e.taken = (ux >= uy);
            default: e.taken = 1'b0;
        endcase
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        #2;
        if (reset_n && out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_result: got tag %0h, expected none",
                         out_tag);
            end else begin
                mon_e = q.pop_front();
                check("out_tag", out_tag, mon_e.tag);
                check("out_taken", out_taken, mon_e.taken);
                check("out_err", out_err, mon_e.err);
            end
        end
    end

    // One cycle: inputs already driven at this negedge
    task automatic step();
        #2;
        last_acc = reset_n && in_valid && in_ready;
        if (last_acc) q.push_back(model(a, b, op, in_tag));
        if (flush || !reset_n) q.delete();
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [2:0] o, input logic [TAG_W-1:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        op = o;
        in_tag = t;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept of tag %0h", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_tag", out_tag, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        // equal operands, exact two-cycle latency
        send(32'h5, 32'h5, 3'd0, 5'd3);
        check("lat1_out_valid", out_valid, 0);
        step();
        check("lat2_out_valid", out_valid, 1);
        check("lat2_out_taken", out_taken, 1);
        check("lat2_out_tag", out_tag, 3);
        drain();

        // signed vs unsigned on all-ones, and a reserved op
        send(32'hFFFF_FFFF, 32'h1, 3'd2, 5'd4);
        send(32'hFFFF_FFFF, 32'h1, 3'd4, 5'd5);
        send($urandom, $urandom, 3'd7, 5'd6);
        send($urandom, $urandom, 3'd6, 5'd7);
        drain();

        // back-pressure: two accepts fill the pipe, outputs hold
        send(32'h10, 32'h10, 3'd0, 5'd8);
        send(32'h10, 32'h11, 3'd1, 5'd9);
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 32'h3;
        b = 32'h2;
        op = 3'd3;
        in_tag = 5'd10;
        #1;
        st_tag = out_tag;
        st_taken = out_taken;
        repeat (3) begin
            step();
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_tag", out_tag, st_tag);
            check("stall_out_taken", out_taken, st_taken);
        end
        check("stall_accepts", q.size(), 2);
        out_ready = 1'b1;
        send(32'h3, 32'h2, 3'd3, 5'd10);
        send(32'h2, 32'h3, 3'd5, 5'd11);
        drain();

        // flush with both stages valid
        send(32'h1, 32'h1, 3'd0, 5'h1A);
        send(32'h1, 32'h2, 3'd0, 5'h1B);
        flush = 1'b1;
        in_valid = 1'b1;
        in_tag = 5'h1C;
        #1;
        check("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("post_flush_out_valid", out_valid, 0);
        drain();

        // reset while requests are in flight
        send(32'h4, 32'h4, 3'd0, 5'h12);
        send(32'h4, 32'h5, 3'd0, 5'h13);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        step();
        reset_n = 1'b1;
        drain();

        // random traffic with back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            op = 3'($urandom_range(0, 7));
            in_tag = TAG_W'($urandom);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        drain();

`ifdef CMP_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("clr_total_cnt", total_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            send(32'h9, 32'h9, 3'd0, TAG_W'(i));
        end
        drain();
        check("sat_total_cnt", total_cnt, 15);
        check("sat_taken_cnt", taken_cnt, 15);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("clr2_total_cnt", total_cnt, 0);
        check("clr2_taken_cnt", taken_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/branch_cmp_pipe.md
BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 8..64).
REQ-002 SHALL have parameter TAG_W, default 5, width of the pass-through tag (destination or PC index).
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-009 SHALL have ports a, b  input  WIDTH  operands.
REQ-010 SHALL have port op  input  3  comparison code (cmp_op_t).
REQ-011 SHALL have port in_tag  input  TAG_W  request tag.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port out_taken  output  1  comparison outcome.
REQ-015 SHALL have port out_err  output  1  reserved op code was received.
REQ-016 SHALL have port out_tag  output  TAG_W  tag of the result.

Function
REQ-017 SHALL implement a two-stage pipeline: S1 registers a, b, op, in_tag; S2 registers the computed result, err and tag.
REQ-018 SHALL give a latency of exactly 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-019 SHALL sustain one accepted request per cycle when out_ready is high.
REQ-020 SHALL advance S2 when !s2_valid || out_ready, and S1 when !s1_valid || S2 advances; in_ready SHALL equal the S1 advance condition AND !flush.
REQ-021 SHALL hold out_valid, out_taken, out_err and out_tag stable while out_valid && !out_ready.
REQ-022 SHALL decode ops: 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU; signed compares SHALL use two's complement over the full WIDTH.
REQ-023 SHALL, for op 6 or 7, drive out_taken=0 and out_err=1; out_err SHALL be 0 for all other ops.
REQ-024 SHALL, on flush, clear s1_valid and s2_valid at the next edge and accept no input that cycle; flush SHALL take priority over every handshake in the same cycle.
REQ-025 SHALL leave data registers unchanged when the matching valid bit is low; their contents SHALL not affect the outputs.

Reset
REQ-026 SHALL, while reset_n is low, asynchronously force s1_valid=0, s2_valid=0, out_valid=0, out_taken=0, out_err=0, out_tag=0 and statistics counters to 0.
REQ-027 SHALL drive in_ready=0 while reset_n is low, and SHALL drive in_ready=1 in the first cycle after reset_n deasserts.
REQ-028 SHALL discard in-flight requests when reset asserts mid-operation; no result for them SHALL appear after reset.

Configuration
REQ-029 SHALL compile statistics logic only when the macro CMP_STATS_EN is defined.
REQ-030 With CMP_STATS_EN defined, SHALL add the input port stats_clr (1 bit) and the output ports total_cnt (CNT_W) and taken_cnt (CNT_W).
REQ-031 With CMP_STATS_EN defined, SHALL increment total_cnt on each output handshake, increment taken_cnt when that result has out_taken=1, saturate both counters at all-ones, and not count flushed requests.
REQ-032 With CMP_STATS_EN defined, SHALL have stats_clr zero both counters synchronously, with stats_clr taking priority over a same-cycle increment.
REQ-033 Without CMP_STATS_EN, SHALL omit stats_clr, total_cnt, taken_cnt and their registers.

Structure
REQ-034 SHALL import cmp_op_t (3-bit enum) and the op code constants from the shared package cmp_pkg.
REQ-035 SHALL compute the outcome in one combinational sub-module, cmp_core, with inputs a, b, op and outputs taken, err, instantiated between S1 and S2.

Verification
REQ-036 SHALL verify a=32'h0000_0005, b=32'h0000_0005, op=EQ, in_tag=3: out_valid=1 and out_taken=1 with out_tag=3 exactly 2 cycles later.
REQ-037 SHALL verify a=32'hFFFF_FFFF, b=32'h0000_0001: op=LT gives out_taken=1, and op=LTU gives out_taken=0.
REQ-038 SHALL verify 4 back-to-back requests with out_ready=0 from cycle 2: in_ready drops after 2 accepts, outputs stay stable, and all 4 results drain in order once out_ready=1.
REQ-039 SHALL verify flush asserted while both stages are valid: out_valid=0 the next cycle, and the flushed tags never appear.
REQ-040 SHALL verify op=7: out_err=1 and out_taken=0.
REQ-041 SHALL verify, with CMP_STATS_EN and CNT_W=4, 20 taken results: total_cnt and taken_cnt saturate at 15, then stats_clr zeroes both.
